// File: rtl/btg_pkg.sv
// Shared constants for the binary/Gray converter: default word width and
// the encoding of the per-word mode select.
package btg_pkg;

  localparam int BTG_DEFAULT_WIDTH = 4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary converter: prefix XOR running from the MSB
// down, so each binary bit is the parity of all Gray bits at or above it.
module gray_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Ripple the running parity from the MSB toward bit 0.
  always_comb begin
    bin            = '0;
    bin[WIDTH-1]   = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary<->Gray converter, one word per cycle, one cycle latency.
// mode selects encode (binary to Gray) or decode (Gray to binary) per word.
// Optional feature: define BINARY_TO_GRAY_ADJ_CHECK_EN to add adj_err, which
// flags a decode-mode input that differs in more than one bit from the
// previous decode-mode input (stream is not a valid Gray sequence).
module binary_to_gray
  import btg_pkg::*;
#(
  parameter int WIDTH = BTG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
`ifdef BINARY_TO_GRAY_ADJ_CHECK_EN
  output logic             adj_err,
`endif
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] enc_p0;
  logic [WIDTH-1:0] dec_p0;
  logic [WIDTH-1:0] res_p0;
  logic [WIDTH-1:0] gray_p1;
  logic             vld_p1;

  // ---- stage p0: combinational conversion of the incoming word ----
  assign enc_p0 = {bin[WIDTH-1], bin[WIDTH-1:1] ^ bin[WIDTH-2:0]};

  gray_decode #(
    .WIDTH (WIDTH)
  ) u_gray_decode (
    .gray (bin),
    .bin  (dec_p0)
  );

  assign res_p0 = (mode == MODE_DEC) ? dec_p0 : enc_p0;

  // ---- stage p1: result register; gray holds when no word is accepted ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      gray_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        gray_p1 <= res_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign gray      = gray_p1;

`ifdef BINARY_TO_GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_p1;
  logic             have_prev_p1;
  logic             adj_p1;
  logic [WIDTH-1:0] diff_p0;
  logic             multi_p0;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign diff_p0  = bin ^ prev_p1;
  assign multi_p0 = (diff_p0 & (diff_p0 - WIDTH'(1))) != '0;

  // Track the last decode-mode input; encode words neither flag nor update it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adj_p1       <= 1'b0;
      have_prev_p1 <= 1'b0;
      prev_p1      <= '0;
    end else begin
      adj_p1 <= 1'b0;
      if (in_valid && (mode == MODE_DEC)) begin
        adj_p1       <= have_prev_p1 && multi_p0;
        prev_p1      <= bin;
        have_prev_p1 <= 1'b1;
      end
    end
  end

  assign adj_err = adj_p1;
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed and randomized bench for binary_to_gray at WIDTH=4, compared
// against an arithmetic reference model of Gray encode/decode.
module tb_binary_to_gray;
  import btg_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         mode;
  logic [W-1:0] bin;
  logic         out_valid;
  logic [W-1:0] gray;
`ifdef BINARY_TO_GRAY_ADJ_CHECK_EN
  logic         adj_err;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] exp_g;
  logic         exp_v;
  logic         exp_a;
  logic [W-1:0] ref_prev;
  logic         ref_have_prev;

  logic [3:0] sweep_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  binary_to_gray #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .bin       (bin),
    .out_valid (out_valid),
`ifdef BINARY_TO_GRAY_ADJ_CHECK_EN
    .adj_err   (adj_err),
`endif
    .gray      (gray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_enc(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // binary value whose encoding equals g: search the code space
  function automatic logic [W-1:0] ref_dec(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < (1 << W); k++) begin
      if (ref_enc(W'(k)) == g) r = W'(k);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic m, input logic [W-1:0] b);
    rst_n    = r;
    in_valid = v;
    mode     = m;
    bin      = b;
    if (!r) begin
      exp_g         = '0;
      exp_v         = 1'b0;
      exp_a         = 1'b0;
      ref_have_prev = 1'b0;
    end else begin
      exp_v = v;
      exp_a = 1'b0;
      if (v) begin
        exp_g = m ? ref_dec(b) : ref_enc(b);
        if (m) begin
          exp_a         = ref_have_prev && ($countones(b ^ ref_prev) > 1);
          ref_prev      = b;
          ref_have_prev = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("gray", 32'(gray), 32'(exp_g));
`ifdef BINARY_TO_GRAY_ADJ_CHECK_EN
    chk("adj_err", 32'(adj_err), 32'(exp_a));
`endif
  endtask

  initial begin
    logic [W-1:0] g1;
    logic [W-1:0] g2;
    logic [W-1:0] rb;
    exp_g = '0; exp_v = 1'b0; exp_a = 1'b0;
    ref_prev = '0; ref_have_prev = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; mode = MODE_ENC; bin = '0;

    // reset state
    step(1'b0, 1'b0, MODE_ENC, '0);
    step(1'b0, 1'b0, MODE_ENC, '0);
    chk("reset_gray", 32'(gray), 32'h0);

    // encode sweep 0..15 with one-bit adjacency, including wrap
    g1 = '0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, MODE_ENC, W'(i));
      chk($sformatf("sweep_%0d", i), 32'(gray), 32'(sweep_tbl[i]));
      if (i > 0) chk($sformatf("sweep_adj_%0d", i), 32'($countones(gray ^ g1)), 32'd1);
      g1 = gray;
    end
    step(1'b1, 1'b1, MODE_ENC, 4'h0);
    chk("sweep_wrap_adj", 32'($countones(gray ^ g1)), 32'd1);

    // decode directed values
    step(1'b1, 1'b1, MODE_DEC, 4'h7);
    chk("dec_0111", 32'(gray), 32'h5);
    step(1'b1, 1'b1, MODE_DEC, 4'h8);
    chk("dec_1000", 32'(gray), 32'hF);

    // round trip of all words, mode switching back to back
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, MODE_ENC, W'(i));
      rb = gray;
      step(1'b1, 1'b1, MODE_DEC, rb);
      chk($sformatf("roundtrip_%0d", i), 32'(gray), 32'(i));
    end

    // wrap 1111 -> 0000
    step(1'b1, 1'b1, MODE_ENC, 4'hF);
    g1 = gray;
    chk("wrap_f", 32'(gray), 32'h8);
    step(1'b1, 1'b1, MODE_ENC, 4'h0);
    g2 = gray;
    chk("wrap_0", 32'(gray), 32'h0);
    chk("wrap_onebit", 32'($countones(g1 ^ g2)), 32'd1);

    // reset overrides a valid word; the word never appears
    step(1'b1, 1'b1, MODE_ENC, 4'h5);
    step(1'b0, 1'b1, MODE_ENC, 4'hA);
    chk("rst_ovr_vld", 32'(out_valid), 32'h0);
    chk("rst_ovr_gray", 32'(gray), 32'h0);
    step(1'b1, 1'b0, MODE_ENC, 4'h0);
    chk("rst_after_vld", 32'(out_valid), 32'h0);
    chk("rst_after_gray", 32'(gray), 32'h0);

    // valid pattern 1,0,1 with hold
    step(1'b1, 1'b1, MODE_ENC, 4'h3);
    chk("pat_a", 32'(gray), 32'h2);
    step(1'b1, 1'b0, MODE_ENC, W'($urandom_range(0, 15)));
    chk("pat_hold_vld", 32'(out_valid), 32'h0);
    chk("pat_hold", 32'(gray), 32'h2);
    step(1'b1, 1'b1, MODE_ENC, 4'h4);
    chk("pat_c", 32'(gray), 32'h6);

`ifdef BINARY_TO_GRAY_ADJ_CHECK_EN
    step(1'b0, 1'b0, MODE_ENC, '0);
    step(1'b1, 1'b1, MODE_DEC, 4'h0);
    chk("adj_0000", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, MODE_DEC, 4'h1);
    chk("adj_0001", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, MODE_ENC, 4'hF);
    chk("adj_enc", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, MODE_DEC, 4'h7);
    chk("adj_0111", 32'(adj_err), 32'h1);
    step(1'b0, 1'b0, MODE_ENC, '0);
    step(1'b1, 1'b1, MODE_DEC, 4'hF);
    chk("adj_first", 32'(adj_err), 32'h0);
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
